// File: rtl/masterslave_sync_source.sv
// Upstream feeder for the master/slave test case: buffers tagged 32-bit words in a FIFO
// and replays each one as a value plus one-cycle sync strobe on its channel, with a minimum gap between strobes.
module masterslave_sync_source #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [31:0]        m_in,
  input  logic                      m_in_ch,
  input  logic                      m_in_valid,
  output logic                      m_in_ready,
  output logic signed [31:0]        s_in,
  output logic                      s_in_sync,
  output logic signed [31:0]        s_in2,
  output logic                      s_in2_sync,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic                     ch;
  } entry_t;

  typedef enum logic [1:0] {
    SEC_IDLE = 2'd0,
    SEC_EMIT = 2'd1,
    SEC_GAP  = 2'd2
  } sec_t;

  entry_t                    mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]          level_q, level_d;
  sec_t                      sec_q, sec_d;
  logic [CNT_W-1:0]          gap_q, gap_d;
  logic signed [DATA_W-1:0]  s_in_q, s_in_d;
  logic signed [DATA_W-1:0]  s_in2_q, s_in2_d;
  logic                      sync_q, sync_d;
  logic                      sync2_q, sync2_d;

  logic                      push_c;
  logic                      pop_c;
  logic                      empty_c;
  entry_t                    rd_entry_c;

  // Ready comes from the registered level only; a full FIFO never bypasses.
  assign m_in_ready = !rst && (level_q < LVL_W'(DEPTH));
  assign push_c     = m_in_valid && m_in_ready;
  assign empty_c    = (level_q == '0);
  assign rd_entry_c = mem_q[rd_ptr_q];

  // Section machine: pops happen only on the edge that enters SEC_EMIT.
  always_comb begin
    sec_d = sec_q;
    gap_d = gap_q;
    pop_c = 1'b0;
    unique case (sec_q)
      SEC_IDLE: begin
        if (!empty_c) begin
          sec_d = SEC_EMIT;
          pop_c = 1'b1;
        end
      end
      SEC_EMIT: begin
        if (GAP > 0) begin
          sec_d = SEC_GAP;
          gap_d = CNT_W'(GAP - 1);
        end else if (!empty_c) begin
          sec_d = SEC_EMIT;
          pop_c = 1'b1;
        end else begin
          sec_d = SEC_IDLE;
        end
      end
      SEC_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - CNT_W'(1);
        end else if (!empty_c) begin
          sec_d = SEC_EMIT;
          pop_c = 1'b1;
        end else begin
          sec_d = SEC_IDLE;
        end
      end
      default: sec_d = SEC_IDLE;
    endcase
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Slave outputs hold their last value; strobes last exactly one cycle.
  always_comb begin
    s_in_d  = s_in_q;
    s_in2_d = s_in2_q;
    sync_d  = 1'b0;
    sync2_d = 1'b0;
    if (pop_c) begin
      if (rd_entry_c.ch) begin
        s_in2_d = rd_entry_c.data;
        sync2_d = 1'b1;
      end else begin
        s_in_d  = rd_entry_c.data;
        sync_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sec_q    <= SEC_IDLE;
      gap_q    <= '0;
      s_in_q   <= '0;
      s_in2_q  <= '0;
      sync_q   <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sec_q    <= sec_d;
      gap_q    <= gap_d;
      s_in_q   <= s_in_d;
      s_in2_q  <= s_in2_d;
      sync_q   <= sync_d;
      sync2_q  <= sync2_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{data: m_in, ch: m_in_ch};
  end

  assign s_in       = s_in_q;
  assign s_in2      = s_in2_q;
  assign s_in_sync  = sync_q;
  assign s_in2_sync = sync2_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_masterslave_sync_source.sv
// Scoreboard bench for masterslave_sync_source: three instances (GAP=1, GAP=3, GAP=0),
// stimulus pushes expected words, a negedge monitor pops and compares on every strobe.
module tb_masterslave_sync_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       vld, ch, rdy, sy0, sy1;
  logic [2:0][31:0] din, v0, v1;
  logic [2:0][2:0]  lvl;

  masterslave_sync_source #(.DEPTH(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .m_in(din[0]), .m_in_ch(ch[0]), .m_in_valid(vld[0]),
    .m_in_ready(rdy[0]), .s_in(v0[0]), .s_in_sync(sy0[0]), .s_in2(v1[0]),
    .s_in2_sync(sy1[0]), .fifo_level(lvl[0]));
  masterslave_sync_source #(.DEPTH(4), .GAP(3)) u_b (
    .clk(clk), .rst(rst), .m_in(din[1]), .m_in_ch(ch[1]), .m_in_valid(vld[1]),
    .m_in_ready(rdy[1]), .s_in(v0[1]), .s_in_sync(sy0[1]), .s_in2(v1[1]),
    .s_in2_sync(sy1[1]), .fifo_level(lvl[1]));
  masterslave_sync_source #(.DEPTH(4), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .m_in(din[2]), .m_in_ch(ch[2]), .m_in_valid(vld[2]),
    .m_in_ready(rdy[2]), .s_in(v0[2]), .s_in_sync(sy0[2]), .s_in2(v1[2]),
    .s_in2_sync(sy1[2]), .fifo_level(lvl[2]));

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q2[$];

  int ncyc = 0;
  int last_cyc[3] = '{-1, -1, -1};
  int nstrobe[3]  = '{0, 0, 0};
  int run[3]      = '{0, 0, 0};
  int maxrun[3]   = '{0, 0, 0};
  int maxlvl[3]   = '{0, 0, 0};
  int spc_a[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [32:0] e);
    case (i)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [32:0] e);
    case (i)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  // Monitor: every strobe is checked against the head of that instance's queue.
  task automatic mon(input int i);
    logic [32:0] e;
    if (int'(lvl[i]) > maxlvl[i]) maxlvl[i] = int'(lvl[i]);
    if (sy0[i] || sy1[i]) begin
      check($sformatf("u%0d_sync_exclusive", i), 32'(sy0[i] & sy1[i]), 32'd0);
      if (last_cyc[i] >= 0) begin
        check($sformatf("u%0d_strobe_spacing_ok", i), 32'((ncyc - last_cyc[i]) > gap_of(i)), 32'd1);
        if (i == 0) spc_a.push_back(ncyc - last_cyc[i]);
      end
      last_cyc[i] = ncyc;
      nstrobe[i]++;
      run[i]++;
      if (run[i] > maxrun[i]) maxrun[i] = run[i];
      check($sformatf("u%0d_strobe_expected", i), 32'(qsize(i) != 0), 32'd1);
      if (qsize(i) != 0) begin
        pop_exp(i, e);
        check($sformatf("u%0d_sb_channel", i), 32'(sy1[i]), 32'(e[32]));
        check($sformatf("u%0d_sb_value", i), sy1[i] ? v1[i] : v0[i], e[31:0]);
      end
    end else begin
      run[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        last_cyc[i] = -1;
        run[i] = 0;
      end else begin
        mon(i);
      end
    end
  end

  task automatic push(input int i, input logic c, input logic [31:0] d, output time t);
    int n;
    n = 0;
    t = 0;
    @(negedge clk);
    din[i] = d;
    ch[i]  = c;
    vld[i] = 1'b1;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      check($sformatf("u%0d_push_ready_timeout", i), 32'(rdy[i]), 32'd1);
      vld[i] = 1'b0;
    end else begin
      @(posedge clk);
      t = $time;
      push_exp(i, {c, d});
    end
  endtask

  task automatic stop(input int i);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((qsize(i) != 0 || lvl[i] != 3'd0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_drain", i), 32'(qsize(i)), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] wv[10] = '{32'd1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,
                          32'd12345, 32'hFFFFCFC7, 32'h7FFF0000, 32'd3, 32'hFFFFFFF9};

  initial begin
    time t, t4;
    int  nb;
    rst = 1'b1;
    vld = '0;
    ch  = '0;
    din = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_rst_ready", i), 32'(rdy[i]), 32'd0);
      check($sformatf("u%0d_rst_level", i), 32'(lvl[i]), 32'd0);
      check($sformatf("u%0d_rst_sync", i), 32'(sy0[i] | sy1[i]), 32'd0);
      check($sformatf("u%0d_rst_s_in", i), v0[i], 32'd0);
      check($sformatf("u%0d_rst_s_in2", i), v1[i], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("u%0d_ready_after_rst", i), 32'(rdy[i]), 32'd1);

    // Single word: strobe only in the cycle after the popping edge.
    push(0, 1'b0, 32'd42, t);
    stop(0);
    check("single_level_after_push", 32'(lvl[0]), 32'd1);
    check("single_no_early_sync", 32'(sy0[0]), 32'd0);
    @(negedge clk);
    check("single_sync", 32'(sy0[0]), 32'd1);
    check("single_value", v0[0], 32'd42);
    check("single_other_sync", 32'(sy1[0]), 32'd0);
    check("single_level_after_pop", 32'(lvl[0]), 32'd0);
    @(negedge clk);
    check("single_sync_one_cycle", 32'(sy0[0]), 32'd0);
    repeat (10) @(negedge clk);
    check("single_value_held", v0[0], 32'd42);

    // Channel steering with GAP=1: period of two cycles.
    spc_a.delete();
    push(0, 1'b0, 32'd7, t);
    push(0, 1'b1, 32'hFFFFFFFB, t);
    push(0, 1'b1, 32'd9, t);
    stop(0);
    drain(0);
    check("steer_strobes", 32'(spc_a.size()), 32'd3);
    if (spc_a.size() == 3) begin
      check("steer_spacing_1", 32'(spc_a[1]), 32'd2);
      check("steer_spacing_2", 32'(spc_a[2]), 32'd2);
    end
    check("steer_s_in_untouched", v0[0], 32'd7);
    check("steer_s_in2_last", v1[0], 32'd9);

    // Full FIFO behind GAP=3.
    for (int k = 0; k < 5; k++) push(1, 1'(k % 2), 32'(100 + k), t);
    t4 = t;
    @(negedge clk);
    check("full_level", 32'(lvl[1]), 32'd4);
    check("full_ready_low", 32'(rdy[1]), 32'd0);
    push(1, 1'b1, 32'd105, t);
    check("full_fifth_accept_delay", 32'(t - t4), 32'd20);
    stop(1);
    drain(1);
    check("full_strobe_count", 32'(nstrobe[1]), 32'd6);
    check("full_max_level", 32'(maxlvl[1]), 32'd4);

    // GAP=0 streaming: eight back-to-back strobes, level never above one.
    for (int k = 0; k < 8; k++) push(2, 1'(k % 3 == 2), 32'(1000 - 37 * k), t);
    stop(2);
    drain(2);
    check("stream_run", 32'(maxrun[2]), 32'd8);
    check("stream_max_level", 32'(maxlvl[2]), 32'd1);
    check("stream_count", 32'(nstrobe[2]), 32'd8);

    // Wrap-around with extreme values.
    nb = nstrobe[0];
    for (int k = 0; k < 10; k++) push(0, 1'(k % 3 == 1), wv[k], t);
    stop(0);
    drain(0);
    check("wrap_count", 32'(nstrobe[0] - nb), 32'd10);

    // Reset while a strobe is live and three words are buffered.
    for (int k = 0; k < 6; k++) push(0, 1'b0, 32'(500 + k), t);
    @(negedge clk);
    vld[0] = 1'b0;
    check("rst_pre_sync", 32'(sy0[0]), 32'd1);
    check("rst_pre_level", 32'(lvl[0]), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_sync", 32'(sy0[0]), 32'd0);
    check("rst_mid_s_in", v0[0], 32'd0);
    check("rst_mid_level", 32'(lvl[0]), 32'd0);
    check("rst_mid_ready", 32'(rdy[0]), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    nb = nstrobe[0];
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_stale_strobe", 32'(nstrobe[0] - nb), 32'd0);
    check("rst_after_level", 32'(lvl[0]), 32'd0);
    check("rst_after_s_in", v0[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
